// File: rtl/mux21_rr_arbiter_if.sv
// Stream bundle between two requesters, the round-robin arbiter and the shared sink.
// The arbiter connects through the slave modport; the environment uses master.
interface mux21_rr_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              s;
  logic              busy;
  logic [CNT_W-1:0]  pkts0;
  logic [CNT_W-1:0]  pkts1;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last,
    output s, busy, pkts0, pkts1
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last,
    input  s, busy, pkts0, pkts1
  );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin packet arbiter driving the select of a 2:1 stream mux.
// A grant is held for a whole packet; the datapath is combinational from the
// registered grant so beats pass with zero latency.
module mux21_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mux21_rr_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t             r_state;
  logic               r_s;
  logic               r_last_srv;
  logic [CNT_W-1:0]   r_pkts0;
  logic [CNT_W-1:0]   r_pkts1;

  logic               w_eop0;
  logic               w_eop1;
  logic               w_out_valid;
  logic [DATA_W-1:0]  w_out_data;
  logic               w_out_last;
  logic               w_in0_ready;
  logic               w_in1_ready;

  // End of packet: final beat accepted on the granted channel.
  assign w_eop0 = (r_state == GNT0) & bus.in0_valid & bus.out_ready & bus.in0_last;
  assign w_eop1 = (r_state == GNT1) & bus.in1_valid & bus.out_ready & bus.in1_last;

  // Steer the granted stream to the output and route the sink's ready back to it.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = {DATA_W{1'b0}};
    w_out_last  = 1'b0;
    w_in0_ready = 1'b0;
    w_in1_ready = 1'b0;
    case (r_state)
      GNT0: begin
        w_out_valid = bus.in0_valid;
        w_out_data  = bus.in0_data;
        w_out_last  = bus.in0_last;
        w_in0_ready = bus.out_ready;
      end
      GNT1: begin
        w_out_valid = bus.in1_valid;
        w_out_data  = bus.in1_data;
        w_out_last  = bus.in1_last;
        w_in1_ready = bus.out_ready;
      end
      default: begin
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Grant FSM: arbitrate from IDLE, hold for a packet, hand over at packet end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s        <= 1'b0;
      r_last_srv <= 1'b1;
      r_pkts0    <= {CNT_W{1'b0}};
      r_pkts1    <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in0_valid && bus.in1_valid) begin
            // Contention: serve the channel that was not served last.
            if (r_last_srv) begin
              r_state <= GNT0;
              r_s     <= 1'b0;
            end else begin
              r_state <= GNT1;
              r_s     <= 1'b1;
            end
          end else if (bus.in0_valid) begin
            r_state <= GNT0;
            r_s     <= 1'b0;
          end else if (bus.in1_valid) begin
            r_state <= GNT1;
            r_s     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        GNT0: begin
          if (w_eop0) begin
            r_last_srv <= 1'b0;
            r_pkts0    <= r_pkts0 + {{(CNT_W-1){1'b0}}, 1'b1};
            // The own valid sampled here is that of the final beat, so the grant
            // stays put unless the other channel is waiting.
            if (bus.in1_valid) begin
              r_state <= GNT1;
              r_s     <= 1'b1;
            end else if (bus.in0_valid) begin
              r_state <= GNT0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= GNT0;
          end
        end
        GNT1: begin
          if (w_eop1) begin
            r_last_srv <= 1'b1;
            r_pkts1    <= r_pkts1 + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bus.in0_valid) begin
              r_state <= GNT0;
              r_s     <= 1'b0;
            end else if (bus.in1_valid) begin
              r_state <= GNT1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= GNT1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_last  = w_out_last;
  assign bus.in0_ready = w_in0_ready;
  assign bus.in1_ready = w_in1_ready;
  assign bus.s         = r_s;
  assign bus.busy      = (r_state != IDLE);
  assign bus.pkts0     = r_pkts0;
  assign bus.pkts1     = r_pkts1;

endmodule
